// File: rtl/cell_result_serializer.sv
// rtl/cell_result_serializer.sv - snapshot a 73-bit cell-output vector and stream it as an 11-byte frame
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cells_in    - cell-library outputs (async to clk), bit n = cell n
//   cap_req     - capture request, level-sampled
//   byte_ready  - consumer ready for byte_out
//   byte_out    - current frame byte (0 when not streaming)
//   byte_valid  - byte_out valid (high throughout SHIFT)
//   byte_idx    - index 0..10 of the current byte
//   busy        - any state other than IDLE
//   done        - one-cycle pulse after byte 10 is accepted
//   overrun     - sticky: cap_req seen while busy, cleared on the next accepted capture
module cell_result_serializer #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [72:0] cells_in,
  input  logic        cap_req,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [3:0]  byte_idx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, SETTLE, SHIFT, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
  localparam bit         NO_SETTLE   = (SETTLE_CYC == 0);

  state_t      state;
  state_t      state_nxt;
  logic [72:0] sync_meta;
  logic [72:0] sync_q;
  logic [72:0] snapshot;
  logic [3:0]  settle_cnt;
  logic [3:0]  idx;
  logic [7:0]  checksum;
  logic [7:0]  cur_byte;
  logic        accept;
  logic        last_byte;
  logic        capture;

  // Two-flop synchronizer: the only place cells_in is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= cells_in;
      sync_q    <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = (state == SHIFT) && byte_ready;
    last_byte = accept && (idx == 4'd10);
    case (state)
      IDLE: begin
        if (cap_req) begin
          if (NO_SETTLE) begin
            state_nxt = SHIFT;
            capture   = 1'b1;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Counter is loaded with SETTLE_CYC, so reaching 1 here means this
        // edge is SETTLE_CYC edges after the request was accepted.
        if (settle_cnt <= 4'd1) begin
          state_nxt = SHIFT;
          capture   = 1'b1;
        end
      end
      SHIFT:   if (last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      snapshot   <= '0;
      idx        <= '0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && cap_req && !NO_SETTLE) settle_cnt <= SETTLE_INIT;
      else if (state == SETTLE)                    settle_cnt <= settle_cnt - 4'd1;

      if (capture) snapshot <= sync_q;

      if (accept) idx <= last_byte ? 4'd0 : idx + 4'd1;

      if (cap_req) overrun <= (state != IDLE);
    end
  end

  // Checksum is a pure function of the snapshot, so ready stalls cannot perturb it.
  always_comb begin
    checksum = {7'b0, snapshot[72]};
    for (int k = 0; k < 9; k++) checksum = checksum ^ snapshot[8*k +: 8];
  end

  always_comb begin
    cur_byte = 8'h00;
    if (idx < 4'd9)       cur_byte = snapshot[{idx, 3'b000} +: 8];
    else if (idx == 4'd9) cur_byte = {7'b0, snapshot[72]};
    else                  cur_byte = checksum;
  end

  assign byte_valid = (state == SHIFT);
  assign byte_out   = byte_valid ? cur_byte : 8'h00;
  assign byte_idx   = idx;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule
